// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: serial FIR controller sharing one MAC across all taps, with a circular sample buffer and coefficient ROM addressing.
module fir_mac_sequencer #(
  parameter int NTAPS = 16,
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int ACCW = 26
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   x,
  input  logic            x_valid,
  output logic            x_ready,
  output logic [AW-1:0]   coef_addr,
  input  logic [CW-1:0]   coef_data,
  output logic [ACCW-1:0] y,
  output logic            y_valid,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;
  state_t state, state_n;
  logic [DW-1:0] sbuf [NTAPS];
  logic [AW-1:0] wr_ptr, k, rd_idx;
  logic [DW-1:0] s_reg;
  logic tap_v, accept;
  logic [ACCW-1:0] acc, sum;
  logic signed [DW+CW-1:0] prod;
  assign accept = x_valid && x_ready;
  assign rd_idx = wr_ptr - k;
  assign prod = $signed(s_reg) * $signed(coef_data);
  assign sum = acc + {{(ACCW-DW-CW){prod[DW+CW-1]}}, prod};
  always_comb begin
    x_ready = state == IDLE;
    busy = state != IDLE;
    coef_addr = state == RUN ? k : '0;
    state_n = state == IDLE ? (x_valid ? RUN : IDLE) :
              state == RUN ? (k == AW'(NTAPS-1) ? LAST : RUN) : IDLE;
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  // tap_v marks the cycle where coef_data lines up with the s_reg fetched one cycle earlier
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) sbuf[i] <= '0;
      wr_ptr <= '0;
      k <= '0;
      s_reg <= '0;
      tap_v <= 1'b0;
      acc <= '0;
      y <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      tap_v <= state == RUN;
      if (tap_v) acc <= sum;
      if (accept) begin
        sbuf[wr_ptr] <= x;
        k <= '0;
        acc <= '0;
      end
      if (state == RUN) begin
        s_reg <= sbuf[rd_idx];
        k <= k + AW'(1);
      end
      if (state == LAST) begin
        y <= sum;
        y_valid <= 1'b1;
        wr_ptr <= wr_ptr + AW'(1);
      end
    end
  end
endmodule
